ethernet_phy_seq: RTL and testbench

ETHERNET_PHY_SEQ -- requirements
Module: ethernet_phy_seq

---
 rtl/ethernet_phy_seq.sv | 206 ++++++++++++++++++++
 tb/tb_ethernet_phy_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_phy_seq.sv
// Ethernet PHY bring-up sequencer: hardware reset hold, MDIO config writes,
// then periodic BMSR link polling with failure detection.
module ethernet_phy_seq #(
    parameter logic [4:0]  PHY_ADDR     = 5'h01,
    parameter int unsigned RESET_CYCLES = 2500,
    parameter int unsigned MDC_HALF     = 4,
    parameter int unsigned N_CFG        = 2,
    parameter int unsigned CFG_AW       = 3,
    parameter int unsigned POLL_GAP     = 50000,
    parameter int unsigned MAX_POLLS    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    output logic              ethernet_reset_n,
    output logic              ethernet_mdc,
    output logic              mdio_o,
    output logic              mdio_oe,
    input  logic              mdio_i,
    output logic [CFG_AW-1:0] cfg_index,
    input  logic [4:0]        cfg_reg,
    input  logic [15:0]       cfg_data,
    output logic              init_done,
    output logic              link_up,
    output logic              fail
);

    localparam int unsigned FRAME_GAP = 4 * MDC_HALF;
    localparam int unsigned GAP_MAX   = (POLL_GAP > FRAME_GAP) ? POLL_GAP : FRAME_GAP;
    localparam int unsigned W_HOLD    = $clog2(RESET_CYCLES + 1);
    localparam int unsigned W_GAP     = $clog2(GAP_MAX + 1);
    localparam int unsigned W_HALF    = $clog2(MDC_HALF + 1);
    localparam int unsigned W_POLL    = $clog2(MAX_POLLS + 1);

    localparam logic [W_HOLD-1:0] HOLD_LAST  = W_HOLD'(RESET_CYCLES - 1);
    localparam logic [W_GAP-1:0]  FGAP_LAST  = W_GAP'(FRAME_GAP - 1);
    localparam logic [W_GAP-1:0]  PGAP_LAST  = W_GAP'(POLL_GAP - 1);
    localparam logic [W_HALF-1:0] HALF_LAST  = W_HALF'(MDC_HALF - 1);
    localparam logic [W_POLL-1:0] POLL_LAST  = W_POLL'(MAX_POLLS - 1);
    localparam logic [CFG_AW-1:0] CFG_LAST   = CFG_AW'(N_CFG - 1);

    typedef enum logic [2:0] {
        S_HOLD, S_WR_CFG, S_WAIT_GAP, S_RD_BMSR, S_LINKED, S_FAIL
    } state_t;

    state_t              r_state;
    logic [W_HOLD-1:0]   r_hold_cnt;
    logic [W_GAP-1:0]    r_gap_cnt;
    logic [W_HALF-1:0]   r_half;
    logic [W_POLL-1:0]   r_poll_cnt;
    logic [5:0]          r_bit;
    logic [62:0]         r_shift;
    logic [2:0]          r_rx;
    logic                r_in_frame;
    logic                r_eth_rst_n;
    logic                r_mdc;
    logic                r_mdio_o;
    logic                r_mdio_oe;
    logic [CFG_AW-1:0]   r_cfg_index;
    logic                r_init_done;
    logic                r_link_up;
    logic                r_fail;

    logic                w_is_wr;
    logic [63:0]         w_frame;

    always_comb begin
        w_is_wr = (r_state == S_WR_CFG);
        if (w_is_wr)
            w_frame = {32'hFFFF_FFFF, 2'b01, 2'b01, PHY_ADDR, cfg_reg, 2'b10, cfg_data};
        else
            w_frame = {32'hFFFF_FFFF, 2'b01, 2'b10, PHY_ADDR, 5'd1, 2'b11, 16'hFFFF};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_HOLD;
            r_hold_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_half      <= '0;
            r_poll_cnt  <= '0;
            r_bit       <= '0;
            r_shift     <= '1;
            r_rx        <= '0;
            r_in_frame  <= 1'b0;
            r_eth_rst_n <= 1'b0;
            r_mdc       <= 1'b0;
            r_mdio_o    <= 1'b1;
            r_mdio_oe   <= 1'b0;
            r_cfg_index <= '0;
            r_init_done <= 1'b0;
            r_link_up   <= 1'b0;
            r_fail      <= 1'b0;
        end else if (restart) begin
            r_state     <= S_HOLD;
            r_hold_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_half      <= '0;
            r_poll_cnt  <= '0;
            r_bit       <= '0;
            r_shift     <= '1;
            r_rx        <= '0;
            r_in_frame  <= 1'b0;
            r_eth_rst_n <= 1'b0;
            r_mdc       <= 1'b0;
            r_mdio_o    <= 1'b1;
            r_mdio_oe   <= 1'b0;
            r_cfg_index <= '0;
            r_init_done <= 1'b0;
            r_link_up   <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_hold_cnt  <= '0;
                        r_eth_rst_n <= 1'b1;
                        r_cfg_index <= '0;
                        r_state     <= S_WR_CFG;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                S_WR_CFG, S_RD_BMSR: begin
                    // Each frame is preceded by an idle gap so MDC stays low >= 2 periods.
                    if (!r_in_frame) begin
                        if (r_gap_cnt == FGAP_LAST) begin
                            r_gap_cnt  <= '0;
                            r_in_frame <= 1'b1;
                            r_shift    <= w_frame[62:0];
                            r_bit      <= '0;
                            r_half     <= '0;
                            r_mdio_oe  <= 1'b1;
                            r_mdio_o   <= w_frame[63];
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 1'b1;
                        end
                    end else if (r_half == HALF_LAST) begin
                        r_half <= '0;
                        r_mdc  <= ~r_mdc;
                        if (!r_mdc) begin
                            r_rx <= {r_rx[1:0], mdio_i};
                        end else if (r_bit == 6'd63) begin
                            r_in_frame <= 1'b0;
                            r_mdio_oe  <= 1'b0;
                            r_mdio_o   <= 1'b1;
                            if (w_is_wr) begin
                                if (r_cfg_index == CFG_LAST) begin
                                    r_init_done <= 1'b1;
                                    r_state     <= S_WAIT_GAP;
                                end else begin
                                    r_cfg_index <= r_cfg_index + 1'b1;
                                end
                            end else begin
                                // r_rx[2] holds BMSR bit 2 (third-from-last bit sampled).
                                r_link_up <= r_rx[2];
                                if (r_rx[2]) begin
                                    r_poll_cnt <= '0;
                                    r_state    <= S_LINKED;
                                end else if (r_link_up) begin
                                    r_poll_cnt <= '0;
                                    r_state    <= S_WAIT_GAP;
                                end else if (r_poll_cnt == POLL_LAST) begin
                                    r_poll_cnt <= r_poll_cnt + 1'b1;
                                    r_fail     <= 1'b1;
                                    r_state    <= S_FAIL;
                                end else begin
                                    r_poll_cnt <= r_poll_cnt + 1'b1;
                                    r_state    <= S_WAIT_GAP;
                                end
                            end
                        end else begin
                            r_bit     <= r_bit + 1'b1;
                            r_shift   <= {r_shift[61:0], 1'b1};
                            r_mdio_o  <= r_shift[62];
                            r_mdio_oe <= w_is_wr || (r_bit < 6'd45);
                        end
                    end else begin
                        r_half <= r_half + 1'b1;
                    end
                end
                S_WAIT_GAP, S_LINKED: begin
                    if (r_gap_cnt == PGAP_LAST) begin
                        r_gap_cnt <= '0;
                        r_state   <= S_RD_BMSR;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                S_FAIL: begin
                end
                default: r_state <= S_HOLD;
            endcase
        end
    end

    assign ethernet_reset_n = r_eth_rst_n;
    assign ethernet_mdc     = r_mdc;
    assign mdio_o           = r_mdio_o;
    assign mdio_oe          = r_mdio_oe;
    assign cfg_index        = r_cfg_index;
    assign init_done        = r_init_done;
    assign link_up          = r_link_up;
    assign fail             = r_fail;

endmodule

// File: tb/tb_ethernet_phy_seq.sv
// Scoreboard bench: stimulus queues expected MDIO frames; a PHY-model monitor
// decodes frames off MDC/MDIO, answers BMSR reads and checks each frame.
module tb_ethernet_phy_seq;

    localparam logic [4:0]  PHY_ADDR     = 5'h01;
    localparam int unsigned RESET_CYCLES = 10;
    localparam int unsigned MDC_HALF     = 2;
    localparam int unsigned N_CFG        = 2;
    localparam int unsigned CFG_AW       = 3;
    localparam int unsigned POLL_GAP     = 200;
    localparam int unsigned MAX_POLLS    = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              restart;
    logic              ethernet_reset_n;
    logic              ethernet_mdc;
    logic              mdio_o;
    logic              mdio_oe;
    logic              mdio_i;
    logic [CFG_AW-1:0] cfg_index;
    logic [4:0]        cfg_reg;
    logic [15:0]       cfg_data;
    logic              init_done;
    logic              link_up;
    logic              fail;

    ethernet_phy_seq #(
        .PHY_ADDR(PHY_ADDR), .RESET_CYCLES(RESET_CYCLES), .MDC_HALF(MDC_HALF),
        .N_CFG(N_CFG), .CFG_AW(CFG_AW), .POLL_GAP(POLL_GAP), .MAX_POLLS(MAX_POLLS)
    ) dut (
        .clk(clk), .reset(reset), .restart(restart),
        .ethernet_reset_n(ethernet_reset_n), .ethernet_mdc(ethernet_mdc),
        .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i),
        .cfg_index(cfg_index), .cfg_reg(cfg_reg), .cfg_data(cfg_data),
        .init_done(init_done), .link_up(link_up), .fail(fail)
    );

    always #5 clk = ~clk;

    always_comb begin
        cfg_reg  = (cfg_index == 3'd0) ? 5'd4 : 5'd0;
        cfg_data = (cfg_index == 3'd0) ? 16'h01E1 : 16'h1200;
    end

    typedef struct {
        bit          is_wr;
        logic [4:0]  rg;
        logic [15:0] data;
        bit          exp_link;
        bit          exp_init;
        bit          exp_fail;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] bmsr_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push_wr(input logic [4:0] rg, input logic [15:0] d, input bit init);
        exp_t e;
        e.is_wr = 1'b1; e.rg = rg; e.data = d;
        e.exp_link = 1'b0; e.exp_init = init; e.exp_fail = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_rd(input logic [15:0] bmsr, input bit lnk, input bit fl);
        exp_t e;
        e.is_wr = 1'b0; e.rg = 5'd1; e.data = bmsr;
        e.exp_link = lnk; e.exp_init = 1'b1; e.exp_fail = fl;
        exp_q.push_back(e);
        bmsr_q.push_back(bmsr);
    endtask

    // PHY model + monitor: frames are delimited by MDC idle longer than a period.
    initial begin
        int          idle;
        int          bitn;
        int          pend;
        bit          prev_mdc;
        bit          is_rd;
        logic [63:0] fb, fo, dfb, dfo;
        logic [15:0] resp;
        exp_t        e;
        idle = 0; bitn = 0; pend = -1; prev_mdc = 1'b0; is_rd = 1'b0;
        fb = '0; fo = '0; dfb = '0; dfo = '0; resp = 16'hFFFF;
        mdio_i = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                idle = 0; bitn = 0; pend = -1; prev_mdc = 1'b0; is_rd = 1'b0;
            end else begin
                idle = ethernet_mdc ? 0 : idle + 1;
                if (idle > 2 * int'(MDC_HALF)) begin
                    bitn = 0;
                    is_rd = 1'b0;
                end
                if (ethernet_mdc && !prev_mdc) begin
                    fb = {fb[62:0], mdio_o};
                    fo = {fo[62:0], mdio_oe};
                    bitn++;
                    if (bitn == 46) begin
                        is_rd = (fb[11:10] == 2'b10);
                        resp = 16'hFFFF;
                        if (is_rd && bmsr_q.size() != 0) resp = bmsr_q.pop_front();
                    end
                    if (bitn == 64) begin
                        dfb = fb; dfo = fo; bitn = 0; is_rd = 1'b0;
                        pend = int'(MDC_HALF) + 3;
                    end
                end
                prev_mdc = ethernet_mdc;
                if (pend > 0) pend--;
                if (pend == 0) begin
                    pend = -1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_unexpected: got frame %h expected none", dfb);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_wr) begin
                            check("wr_frame", dfb, {32'hFFFF_FFFF, 2'b01, 2'b01, PHY_ADDR, e.rg, 2'b10, e.data});
                            check("wr_oe", dfo, 64'hFFFF_FFFF_FFFF_FFFF);
                        end else begin
                            check("rd_header", 64'(dfb[63:18]), 64'({32'hFFFF_FFFF, 2'b01, 2'b10, PHY_ADDR, 5'd1}));
                            check("rd_oe", dfo, {46'h3FFF_FFFF_FFFF, 18'h0});
                        end
                        check("link_up_after_frame", 64'(link_up), 64'(e.exp_link));
                        check("init_done_after_frame", 64'(init_done), 64'(e.exp_init));
                        check("fail_after_frame", 64'(fail), 64'(e.exp_fail));
                        check("mdio_oe_between_frames", 64'(mdio_oe), 64'd0);
                    end
                end
            end
            if (is_rd && bitn >= 48)
                mdio_i = resp[4'(63 - bitn)];
            else if (is_rd && bitn == 47)
                mdio_i = 1'b0;
            else
                mdio_i = 1'b1;
        end
    end

    task automatic measure_hold(output int n, output int mdc_hi);
        n = 0;
        mdc_hi = 0;
        while (!ethernet_reset_n && n < 1000) begin
            n++;
            if (ethernet_mdc) mdc_hi++;
            @(negedge clk);
        end
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        int hi;
        int t;
        reset   = 1'b1;
        restart = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_reset_n", 64'(ethernet_reset_n), 64'd0);
        check("rst_mdc", 64'(ethernet_mdc), 64'd0);
        check("rst_mdio_o", 64'(mdio_o), 64'd1);
        check("rst_mdio_oe", 64'(mdio_oe), 64'd0);
        check("rst_cfg_index", 64'(cfg_index), 64'd0);
        check("rst_init_done", 64'(init_done), 64'd0);
        check("rst_link_up", 64'(link_up), 64'd0);
        check("rst_fail", 64'(fail), 64'd0);

        push_wr(5'd4, 16'h01E1, 1'b0);
        push_wr(5'd0, 16'h1200, 1'b1);
        push_rd(16'h7809, 1'b0, 1'b0);
        push_rd(16'h782D, 1'b1, 1'b0);
        push_rd(16'h7809, 1'b0, 1'b0);
        push_rd(16'h782D, 1'b1, 1'b0);

        reset = 1'b0;
        measure_hold(n, hi);
        check("hold_cycles", 64'(n), 64'(RESET_CYCLES));
        check("hold_mdc_high", 64'(hi), 64'd0);
        wait_drain("link_sequence_drain");
        check("linked_link_up", 64'(link_up), 64'd1);
        check("linked_fail", 64'(fail), 64'd0);

        @(negedge clk) restart = 1'b1;
        @(negedge clk) restart = 1'b0;
        check("restart1_link_up", 64'(link_up), 64'd0);
        check("restart1_init_done", 64'(init_done), 64'd0);
        check("restart1_reset_n", 64'(ethernet_reset_n), 64'd0);

        t = 0;
        while (!mdio_oe && t < 2000) begin
            @(negedge clk);
            t++;
        end
        repeat (60) @(negedge clk);
        check("midframe_oe", 64'(mdio_oe), 64'd1);
        check("midframe_cfg_index", 64'(cfg_index), 64'd0);
        restart = 1'b1;
        @(negedge clk) restart = 1'b0;
        check("restart2_mdio_oe", 64'(mdio_oe), 64'd0);
        check("restart2_mdc", 64'(ethernet_mdc), 64'd0);
        check("restart2_init_done", 64'(init_done), 64'd0);
        check("restart2_cfg_index", 64'(cfg_index), 64'd0);

        push_wr(5'd4, 16'h01E1, 1'b0);
        push_wr(5'd0, 16'h1200, 1'b1);
        push_rd(16'h7809, 1'b0, 1'b0);
        push_rd(16'h7809, 1'b0, 1'b0);
        push_rd(16'h7809, 1'b0, 1'b1);
        measure_hold(n, hi);
        check("restart_hold_cycles", 64'(n), 64'(RESET_CYCLES));
        wait_drain("fail_sequence_drain");

        n = 0;
        for (int i = 0; i < 3 * int'(POLL_GAP); i++) begin
            @(negedge clk);
            if (ethernet_mdc || mdio_oe || !fail) n++;
        end
        check("fail_idle_violations", 64'(n), 64'd0);
        check("fail_link_up", 64'(link_up), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
